keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Keypad scan and interrupt controller for the minsys keypad port. It sequences the 4×4 matrix by driving one column low at a time and samples the row lines through a synchronizer. A key is debounced over several scan samples, then latched into a code register that the CPU reads. The controller raises an interrupt request, gated by `EI`, and holds it until the core acknowledges.

## Interface
Parameters:
- `SCAN_DIV`, default 16: clock cycles each column is driven before its rows are sampled. Must be ≥ 4.
- `DEBOUNCE`, default 3: number of consecutive matching samples needed to accept a press, and also to accept a release. Must be ≥ 1.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset; synchronous and active-high.
- `EI`, in, 1: interrupt enable; gates `irq` only.
- `Keypad_rows`, in, 4: row lines, active-low; idle value is 4'b1111.
- `Keypad_cols`, out, 4: column drive, active-low, one-cold.
- `key_code`, out, 4: latched key, computed as row_idx*4 + col_idx.
- `key_valid`, out, 1: a latched key is pending.
- `overrun`, out, 1: sticky flag; a new key was latched while `key_valid` was already pending.
- `key_ack`, in, 1: one-cycle pulse from the CPU that consumes the pending key.
- `irq`, out, 1: equals `key_valid & EI` (combinational).

## Operation
- Rows pass through a 2-flop synchronizer whose reset value is 4'b1111. All decisions use the synchronized value, `rows_s`.
- `col_idx` is a 2-bit index and `Keypad_cols = ~(4'b0001 << col_idx)`.
- `dwell` counts from 0 to SCAN_DIV−1 and wraps. A **sample** occurs on the cycle where `dwell == SCAN_DIV−1`.
- At a sample, the key is "pressed" if any bit of `rows_s` is 0. `row_idx` is the lowest-index 0 bit; multiple rows low resolve to the lowest row.

State machine:
- **SCAN**
  - Sample with no press: `col_idx` increments mod 4.
  - Sample with a press: store the candidate code, set `cnt` = 1, freeze `col_idx`.
    - If DEBOUNCE == 1, latch immediately and go to RELEASE.
    - Otherwise go to CONFIRM.
- **CONFIRM** (column frozen)
  - Sample where the press code equals the candidate: `cnt` increments. When `cnt` reaches DEBOUNCE, latch and go to RELEASE.
  - Sample with no press, or a different code: discard the candidate, `col_idx` increments, return to SCAN.
- **RELEASE** (column frozen)
  - Count consecutive samples with `rows_s == 4'b1111`.
  - After DEBOUNCE such samples, `col_idx` increments and the state returns to SCAN.
  - Any press sample resets the count. No relatch happens while the key is held.

Latch behaviour:
- `key_code` ← candidate and `key_valid` ← 1.
- If `key_valid` was already 1 and `key_ack` is not asserted in that same cycle, `overrun` ← 1. The new code overwrites the old one.

Acknowledge behaviour:
- `key_ack` with no latch in the same cycle clears `key_valid` and `overrun`.
- `key_ack` in the same cycle as a latch: the new key wins. `key_valid` stays 1 and `overrun` is cleared.
- `key_ack` while `key_valid` is 0 has no effect.

`EI` never affects scanning, latching or `key_valid`. It only masks `irq`.

## Timing
Reset values (on the first rising edge with `rst` = 1):
- state SCAN, `col_idx` 0, so `Keypad_cols` = 4'b1110.
- `dwell` 0, `cnt` 0.
- synchronizer 4'b1111.
- `key_code` 0, `key_valid` 0, `overrun` 0, therefore `irq` 0.

`rst` asserted mid-operation aborts any CONFIRM or RELEASE in progress and discards a pending key.

Latency and cadence:
- A row change is visible in `rows_s` 2 cycles later. SCAN_DIV ≥ 4 guarantees rows settle before the sample.
- From the first accepting sample, `key_valid` rises on the edge of the DEBOUNCE-th sample. That is (DEBOUNCE−1)·SCAN_DIV cycles after the first sample.
- A full idle scan sweep takes 4·SCAN_DIV cycles.
- `key_valid` falls on the edge at which `key_ack` is sampled high.
- `irq` follows `EI` in the same cycle.

## Structure
- Package `keypad_pkg`, containing:
  - the state enum (SCAN, CONFIRM, RELEASE);
  - `KEY_W` = 4;
  - a `ROWS_IDLE` constant of 4'b1111.
- Sub-module `keypad_sync`: a 4-bit 2-flop synchronizer with a reset value parameter. It is instantiated once, on `Keypad_rows`.
- The remaining logic forms one FSM plus counters in the top module.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE = 2.
- **Reset:** assert `rst` for 1 edge with rows 4'b1111. Expect `Keypad_cols` = 1110 and `key_valid`/`overrun`/`irq` = 0. Expect columns to cycle 1110→1101→1011→0111 every 4 cycles.
- **Single press:** hold row 2 low only while col 1 is driven, for 3 samples. Expect `key_code` = 9 and `key_valid` = 1 one sample period after the first detect. Release, then assert `key_ack`. Expect `key_valid` = 0 and scanning to resume at col 2.
- **Bounce:** row 0 is low for one col-3 sample, then high. Expect no latch, and the column advancing to col 0.
- **Overrun:** latch code 0, release, then press the key giving code 5 without acking. Expect `key_code` = 5, `key_valid` = 1, `overrun` = 1. A `key_ack` then clears both flags.
- **Acknowledge collision:** `key_ack` in the same cycle as a latch of code 15. Expect `key_valid` = 1 and `overrun` = 0.
- **Gating and abort:** with `EI` = 0, a pending key gives `irq` = 0; toggling `EI` to 1 gives `irq` = 1 in the same cycle. Assert `rst` during RELEASE: all outputs return to their reset values.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared types and constants for the keypad scan controller.
//   state_t      : scan FSM states (SCAN, CONFIRM, RELEASE)
//   KEY_W        : width of a key code (row_idx*4 + col_idx)
//   ROWS_IDLE    : row-line value with no key pressed (rows are active-low)
//   lowest_zero(): index of the lowest 0 bit of a row vector
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Several rows low at once resolve to the lowest-numbered row, so the
  // scan walks from the top down and the last hit wins.
  function automatic logic [1:0] lowest_zero(input logic [3:0] rows);
    lowest_zero = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) lowest_zero = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync -- per-bit two-flop synchronizer for asynchronous row lines.
//   clk   : system clock
//   rst   : synchronous active-high reset, loads RST_VAL into both stages
//   d     : asynchronous input bits
//   q     : synchronized output bits (d delayed by two clock edges)
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = ROWS_IDLE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    always_ff @(posedge clk) begin
      if (rst) begin
        meta_reg[gi] <= RST_VAL[gi];
        sync_reg[gi] <= RST_VAL[gi];
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl -- 4x4 matrix keypad scanner with debounce, a latched
// key-code register and an EI-gated interrupt request.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   EI          : interrupt enable, masks irq only
//   Keypad_rows : row lines, active-low, idle 4'b1111
//   Keypad_cols : column drive, active-low, one-cold
//   key_code    : latched key, row_idx*4 + col_idx
//   key_valid   : a latched key is pending
//   overrun     : sticky, a key was latched over a pending one
//   key_ack     : one-cycle pulse consuming the pending key
//   irq         : key_valid & EI
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EI,
  input  logic [3:0]       Keypad_rows,
  output logic [3:0]       Keypad_cols,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             overrun,
  input  logic             key_ack,
  output logic             irq
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);

  logic [3:0]       rows_s;
  state_t           state_reg;
  logic [1:0]       col_idx_reg;
  logic [DW-1:0]    dwell_reg;
  logic [CW-1:0]    cnt_reg;
  logic [KEY_W-1:0] cand_reg;
  logic [KEY_W-1:0] key_code_reg;
  logic             key_valid_reg;
  logic             overrun_reg;

  logic             sample;
  logic             pressed;
  logic [KEY_W-1:0] press_code;
  logic             latch;

  keypad_sync #(
    .W       (4),
    .RST_VAL (ROWS_IDLE)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (Keypad_rows),
    .q   (rows_s)
  );

  assign sample     = (dwell_reg == DWELL_LAST);
  assign pressed    = (rows_s != ROWS_IDLE);
  assign press_code = {lowest_zero(rows_s), col_idx_reg};

  // A latch happens either on the very first hit (single-sample debounce)
  // or on the sample that brings the matching-hit count up to DEBOUNCE.
  // In CONFIRM the press code equals the candidate, so press_code is the
  // value to store in both cases.
  always_comb begin
    latch = 1'b0;
    if (sample && pressed) begin
      if (state_reg == SCAN && DEBOUNCE == 1) begin
        latch = 1'b1;
      end else if (state_reg == CONFIRM && press_code == cand_reg &&
                   cnt_reg == CNT_LAST) begin
        latch = 1'b1;
      end
    end
  end

  // Scan FSM. The dwell counter free-runs; everything else only moves on
  // sample cycles. cnt_reg counts matching presses in CONFIRM and
  // consecutive idle samples in RELEASE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= SCAN;
      col_idx_reg <= 2'd0;
      dwell_reg   <= '0;
      cnt_reg     <= '0;
      cand_reg    <= '0;
    end else begin
      dwell_reg <= sample ? '0 : dwell_reg + 1'b1;
      if (sample) begin
        case (state_reg)
          SCAN: begin
            if (!pressed) begin
              col_idx_reg <= col_idx_reg + 2'd1;
            end else begin
              cand_reg <= press_code;
              if (DEBOUNCE == 1) begin
                cnt_reg   <= '0;
                state_reg <= RELEASE;
              end else begin
                cnt_reg   <= CW'(1);
                state_reg <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (pressed && press_code == cand_reg) begin
              if (cnt_reg == CNT_LAST) begin
                cnt_reg   <= '0;
                state_reg <= RELEASE;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end else begin
              cnt_reg     <= '0;
              col_idx_reg <= col_idx_reg + 2'd1;
              state_reg   <= SCAN;
            end
          end
          RELEASE: begin
            // Holding the key keeps us here; no relatch until fully released.
            if (pressed) begin
              cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              cnt_reg     <= '0;
              col_idx_reg <= col_idx_reg + 2'd1;
              state_reg   <= SCAN;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: begin
            cnt_reg   <= '0;
            state_reg <= SCAN;
          end
        endcase
      end
    end
  end

  // Key register and flags. A latch coinciding with an ack: the new key
  // stays pending and the ack is taken as having consumed the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else if (latch) begin
      key_code_reg  <= press_code;
      key_valid_reg <= 1'b1;
      overrun_reg   <= key_ack ? 1'b0 : (overrun_reg | key_valid_reg);
    end else if (key_ack && key_valid_reg) begin
      key_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end
  end

  assign Keypad_cols = ~(4'b0001 << col_idx_reg);
  assign key_code    = key_code_reg;
  assign key_valid   = key_valid_reg;
  assign overrun     = overrun_reg;
  assign irq         = key_valid_reg & EI;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl -- directed scenarios followed by randomized key
// activity on a simulated 4x4 matrix; every cycle the DUT outputs are
// compared with a reference model of the scanning rules.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       EI = 1'b1;
  logic       key_ack = 1'b0;
  logic [3:0] rows_phys;
  logic [3:0] Keypad_cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       overrun;
  logic       irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .EI          (EI),
    .Keypad_rows (rows_phys),
    .Keypad_cols (Keypad_cols),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .overrun     (overrun),
    .key_ack     (key_ack),
    .irq         (irq)
  );

  // Physical matrix: a closed switch pulls its row low only while its
  // column is driven low. Up to two keys can be held.
  logic       ka_on = 1'b0, kb_on = 1'b0;
  logic [1:0] ka_r = 2'd0, ka_c = 2'd0, kb_r = 2'd0, kb_c = 2'd0;

  always_comb begin
    rows_phys = 4'b1111;
    if (ka_on && Keypad_cols[ka_c] == 1'b0) rows_phys[ka_r] = 1'b0;
    if (kb_on && Keypad_cols[kb_c] == 1'b0) rows_phys[kb_r] = 1'b0;
  end

  // Reference model state
  logic [3:0] m_q1, m_q2;
  int m_dwell, m_col, m_cand, m_hits, m_idle, m_code, m_latches, m_mark;
  bit m_holding, m_valid, m_ovr;

  initial m_latches = 0;

  task automatic model_edge(input logic r, input logic [3:0] rows_in, input logic ack);
    logic [3:0] rs;
    bit smp, pressed, do_latch;
    int row, code;
    if (r) begin
      m_q1 = 4'hf; m_q2 = 4'hf; m_dwell = 0; m_col = 0; m_cand = -1;
      m_hits = 0; m_idle = 0; m_holding = 0; m_code = 0; m_valid = 0; m_ovr = 0;
      return;
    end
    rs = m_q2;
    smp = (m_dwell == SD - 1);
    do_latch = 0;
    m_q2 = m_q1;
    m_q1 = rows_in;
    m_dwell = (m_dwell + 1) % SD;
    if (smp) begin
      pressed = (rs != 4'hf);
      row = 0;
      for (int i = 3; i >= 0; i--) if (!rs[i]) row = i;
      code = row * 4 + m_col;
      if (m_holding) begin
        if (pressed) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == DB) begin
            m_holding = 0; m_idle = 0; m_col = (m_col + 1) % 4;
          end
        end
      end else if (m_cand < 0) begin
        if (!pressed) m_col = (m_col + 1) % 4;
        else begin
          m_cand = code; m_hits = 1;
          if (m_hits == DB) do_latch = 1;
        end
      end else if (pressed && code == m_cand) begin
        m_hits++;
        if (m_hits == DB) do_latch = 1;
      end else begin
        m_cand = -1; m_col = (m_col + 1) % 4;
      end
    end
    if (do_latch) begin
      m_code = m_cand;
      m_ovr = ack ? 1'b0 : (m_ovr | m_valid);
      m_valid = 1;
      m_holding = 1; m_idle = 0; m_cand = -1;
      m_latches++;
      $display("latch #%0d code=%0d overrun=%0b ack=%0b t=%0t", m_latches, m_code, m_ovr, ack, $time);
    end else if (ack && m_valid) begin
      m_valid = 0; m_ovr = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: capture inputs, advance model on the edge, check on negedge.
  task automatic tick();
    logic r, a;
    logic [3:0] rw, exp_cols;
    #1;
    r = rst; rw = rows_phys; a = key_ack;
    @(posedge clk);
    model_edge(r, rw, a);
    @(negedge clk);
    exp_cols = ~(4'b0001 << m_col);
    chk("cols", Keypad_cols, exp_cols);
    chk("key_code", key_code, 8'(m_code));
    chk("key_valid", key_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("irq", irq, m_valid & EI);
  endtask

  function automatic bit cond(input int what);
    case (what)
      0: return m_latches > m_mark;
      1: return !m_holding && m_cand < 0;
      2: return m_cand >= 0;
      3: return m_col == 3 && m_dwell == 0 && m_cand < 0 && !m_holding;
      4: return m_cand < 0;
      5: return m_dwell == SD - 1;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int what, input string tag);
    for (int i = 0; i < 100 && !cond(what); i++) tick();
    if (!cond(what)) begin
      vectors++;
      miscompares++;
      $error("FAIL %s timeout observed=not-reached expected=reached", tag);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle sweep
    rst = 1'b1; EI = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_cols", Keypad_cols, 8'h0e);
    chk("rst_valid", key_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_irq", irq, 0);
    repeat (SD) tick();
    chk("sweep_c1", Keypad_cols, 8'h0d);
    repeat (SD) tick();
    chk("sweep_c2", Keypad_cols, 8'h0b);
    repeat (SD) tick();
    chk("sweep_c3", Keypad_cols, 8'h07);
    repeat (SD) tick();
    chk("sweep_c0", Keypad_cols, 8'h0e);

    // Single press: row 2 / col 1 -> code 9, one sample period after detect
    ka_r = 2'd2; ka_c = 2'd1; ka_on = 1'b1;
    wait_for(2, "press_detect");
    repeat (SD - 1) tick();
    chk("press_not_yet", key_valid, 0);
    tick();
    chk("press_valid", key_valid, 1);
    chk("press_code", key_code, 8'd9);
    ka_on = 1'b0;
    wait_for(1, "press_release");
    chk("resume_col2", Keypad_cols, 8'h0b);
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    chk("ack_clears", key_valid, 0);

    // Bounce: row 0 low for exactly one col-3 sample
    wait_for(3, "bounce_col3");
    ka_r = 2'd0; ka_c = 2'd3; ka_on = 1'b1;
    wait_for(2, "bounce_detect");
    ka_on = 1'b0;
    wait_for(4, "bounce_discard");
    chk("bounce_col0", Keypad_cols, 8'h0e);
    chk("bounce_nolatch", key_valid, 0);

    // Overrun: code 0, release, code 5 without ack
    ka_r = 2'd0; ka_c = 2'd0; ka_on = 1'b1; m_mark = m_latches;
    wait_for(0, "ovr_first");
    ka_on = 1'b0;
    wait_for(1, "ovr_rel1");
    ka_r = 2'd1; ka_c = 2'd1; ka_on = 1'b1; m_mark = m_latches;
    wait_for(0, "ovr_second");
    chk("ovr_code", key_code, 8'd5);
    chk("ovr_valid", key_valid, 1);
    chk("ovr_flag", overrun, 1);
    ka_on = 1'b0;
    wait_for(1, "ovr_rel2");
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    chk("ovr_ack_valid", key_valid, 0);
    chk("ovr_ack_flag", overrun, 0);

    // Ack collision with a pending key: latch 10, then 15 with ack on the latch edge
    ka_r = 2'd2; ka_c = 2'd2; ka_on = 1'b1; m_mark = m_latches;
    wait_for(0, "col_first");
    ka_on = 1'b0;
    wait_for(1, "col_rel");
    ka_r = 2'd3; ka_c = 2'd3; ka_on = 1'b1;
    wait_for(2, "col_detect");
    tick();
    wait_for(5, "col_presample");
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    chk("col_code", key_code, 8'd15);
    chk("col_valid", key_valid, 1);
    chk("col_overrun", overrun, 0);
    ka_on = 1'b0;
    wait_for(1, "col_rel2");

    // EI gating and reset during RELEASE
    EI = 1'b0; #1;
    chk("gate_irq0", irq, 0);
    EI = 1'b1; #1;
    chk("gate_irq1", irq, 1);
    ka_r = 2'd1; ka_c = 2'd2; ka_on = 1'b1; m_mark = m_latches;
    wait_for(0, "abort_latch");
    rst = 1'b1; ka_on = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_cols", Keypad_cols, 8'h0e);
    chk("abort_code", key_code, 0);
    chk("abort_valid", key_valid, 0);
    chk("abort_overrun", overrun, 0);
    chk("abort_irq", irq, 0);

    // Randomized activity against the model
    for (int n = 0; n < 60; n++) begin
      ka_on = ($urandom_range(0, 3) != 0);
      ka_r = 2'($urandom_range(0, 3)); ka_c = 2'($urandom_range(0, 3));
      kb_on = ($urandom_range(0, 3) == 0);
      kb_r = 2'($urandom_range(0, 3)); kb_c = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) EI = ~EI;
      for (int h = $urandom_range(2, 40); h > 0; h--) begin
        key_ack = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
      key_ack = 1'b0; rst = 1'b0;
      ka_on = 1'b0; kb_on = 1'b0;
      for (int h = $urandom_range(0, 20); h > 0; h--) begin
        key_ack = ($urandom_range(0, 7) == 0);
        tick();
      end
      key_ack = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
